// File: rtl/fmm_pkg.sv
// Shared FMM state encodings and defaults for the BX-synchronised trigger-stop logic.
package fmm_pkg;

   localparam int FMM_STATE_W     = 3;
   localparam int FMM_BXN_MAX_DEF = 3563;

   typedef enum logic [FMM_STATE_W-1:0] {
      FMM_STARTUP  = 3'd0,
      FMM_RESYNC   = 3'd1,
      FMM_WAIT_BX0 = 3'd2,
      FMM_RUN      = 3'd3,
      FMM_ERROR    = 3'd4
   } fmm_state_t;

endpackage

// File: rtl/fmm_bxn_counter.sv
// Orbit-wrapping bunch-crossing counter with offset / offset+1 load controls.
module fmm_bxn_counter #(
   parameter int BXN_WIDTH  = 12,
   parameter int BXN_MAX    = 3563,
   parameter int BXN_OFFSET = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_load_off,
   input  logic                 i_load_off1,
   output logic [BXN_WIDTH-1:0] o_bxn,
   output logic                 o_at_off
);

   localparam logic [BXN_WIDTH-1:0] L_MAX  = BXN_WIDTH'(BXN_MAX);
   localparam logic [BXN_WIDTH-1:0] L_OFF  = BXN_WIDTH'(BXN_OFFSET);
   // BX following the BX0 cycle, wrapping when BX0 sits on the last BX of the orbit
   localparam logic [BXN_WIDTH-1:0] L_OFF1 =
      BXN_WIDTH'((BXN_OFFSET == BXN_MAX) ? 0 : BXN_OFFSET + 1);

   logic [BXN_WIDTH-1:0] r_bxn;

   always_ff @(posedge clock) begin
      if (reset)               r_bxn <= '0;
      else if (i_load_off)     r_bxn <= L_OFF;
      else if (i_load_off1)    r_bxn <= L_OFF1;
      else if (r_bxn == L_MAX) r_bxn <= '0;
      else                     r_bxn <= r_bxn + 1'b1;
   end

   assign o_bxn    = r_bxn;
   assign o_at_off = (r_bxn == L_OFF);

endmodule

// File: rtl/fmm_bx_sync.sv
// FMM trigger-stop state machine with BX counter and continuous BX0 alignment check.
// Optional: FMM_AUTO_RECOVER_EN makes ERROR fall back to WAIT_BX0 instead of sticking.
module fmm_bx_sync
   import fmm_pkg::*;
#(
   parameter int BXN_WIDTH     = 12,
   parameter int BXN_MAX       = FMM_BXN_MAX_DEF,
   parameter int BXN_OFFSET    = 0,
   parameter int MAX_BX0_MISS  = 3,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_ttc_bx0,
   input  logic                     i_ttc_resync,
   input  logic                     i_dont_wait,
   output logic                     o_fmm_trig_stop,
   output logic [BXN_WIDTH-1:0]     o_bxn,
   output logic                     o_bx0_sync_err,
   output logic [ERR_CNT_WIDTH-1:0] o_bx0_err_cnt,
   output logic [FMM_STATE_W-1:0]   o_fmm_state
);

`ifdef FMM_AUTO_RECOVER_EN
   localparam bit L_AUTO = 1'b1;
`else
   localparam bit L_AUTO = 1'b0;
`endif

   localparam int CW = $clog2(MAX_BX0_MISS + 1);

   fmm_state_t             r_state, w_state_nxt;
   logic                   r_trig_stop;
   logic                   r_sync_err;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic [CW-1:0]          r_miss_run;
   logic [BXN_WIDTH-1:0]   w_bxn;
   logic                   w_at_off;
   logic                   w_chk, w_miss, w_good, w_last_miss, w_align;

   assign w_align = (r_state == FMM_WAIT_BX0) && i_ttc_bx0 && !i_ttc_resync;

   fmm_bxn_counter #(
      .BXN_WIDTH (BXN_WIDTH),
      .BXN_MAX   (BXN_MAX),
      .BXN_OFFSET(BXN_OFFSET)
   ) u_bxn (
      .clock      (clock),
      .reset      (reset),
      .i_load_off (i_ttc_resync),
      .i_load_off1(w_align),
      .o_bxn      (w_bxn),
      .o_at_off   (w_at_off)
   );

   // Resync wins over checking; dont_wait masks it entirely
   assign w_chk       = (r_state == FMM_RUN) && !i_dont_wait && !i_ttc_resync;
   assign w_miss      = w_chk && (w_at_off ^ i_ttc_bx0);
   assign w_good      = w_chk && w_at_off && i_ttc_bx0;
   assign w_last_miss = w_miss && ((int'(r_miss_run) + 1) >= MAX_BX0_MISS);

   always_comb begin
      w_state_nxt = r_state;
      if (i_ttc_resync) w_state_nxt = FMM_RESYNC;
      else begin
         case (r_state)
            FMM_STARTUP:  w_state_nxt = FMM_WAIT_BX0;
            FMM_RESYNC:   w_state_nxt = i_ttc_bx0 ? FMM_RUN : FMM_WAIT_BX0;
            FMM_WAIT_BX0: if (i_ttc_bx0 || i_dont_wait) w_state_nxt = FMM_RUN;
            FMM_RUN:      if (w_last_miss) w_state_nxt = FMM_ERROR;
            FMM_ERROR:    w_state_nxt = L_AUTO ? FMM_WAIT_BX0 : FMM_ERROR;
            default:      w_state_nxt = FMM_STARTUP;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= FMM_STARTUP;
         r_trig_stop <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_trig_stop <= (r_state != FMM_RUN);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync_err <= 1'b0;
         r_err_cnt  <= '0;
         r_miss_run <= '0;
      end else begin
         if (w_miss && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
         if (i_ttc_resync) begin
            r_sync_err <= 1'b0;
            r_miss_run <= '0;
         end else if (w_miss) begin
            r_sync_err <= 1'b1;
            r_miss_run <= r_miss_run + 1'b1;
         end else if (w_good || (L_AUTO && r_state == FMM_ERROR)) begin
            // auto-recovery must re-arm the run length or ERROR could never recur
            r_miss_run <= '0;
         end
      end
   end

   assign o_fmm_trig_stop = r_trig_stop;
   assign o_bxn           = w_bxn;
   assign o_bx0_sync_err  = r_sync_err;
   assign o_bx0_err_cnt   = r_err_cnt;
   assign o_fmm_state     = r_state;

endmodule

// File: tb/tb_fmm_bx_sync.sv
// Directed bench for fmm_bx_sync: startup alignment, steady orbits, shifted BX0, resync, dont_wait.
module tb_fmm_bx_sync;

   logic        clock = 1'b0;
   logic        reset;
   logic        ttc_bx0, ttc_resync, dont_wait;
   logic        trig_stop, sync_err;
   logic [11:0] bxn;
   logic [15:0] err_cnt;
   logic [2:0]  state;

   int checks   = 0;
   int failures = 0;

   localparam int ORBIT = 3564;

   fmm_bx_sync dut (
      .clock          (clock),
      .reset          (reset),
      .i_ttc_bx0      (ttc_bx0),
      .i_ttc_resync   (ttc_resync),
      .i_dont_wait    (dont_wait),
      .o_fmm_trig_stop(trig_stop),
      .o_bxn          (bxn),
      .o_bx0_sync_err (sync_err),
      .o_bx0_err_cnt  (err_cnt),
      .o_fmm_state    (state)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_bx0();
      ttc_bx0 = 1'b1;
      tick();
      ttc_bx0 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ttc_bx0 = 1'b0; ttc_resync = 1'b0; dont_wait = 1'b0;
      idle(3);
      checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state); end
      checks++; if (trig_stop !== 1'b1) begin failures++; $display("FAIL reset_trig got=%0b want=1", trig_stop); end
      checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL reset_bxn got=%0d want=0", bxn); end
      checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", sync_err); end
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", err_cnt); end
   endtask

   task automatic test_startup();
      reset = 1'b0;
      tick();
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL start_wait got=%0d want=2", state); end
      idle(4999);
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL start_wait5000 got=%0d want=2", state); end
      checks++; if (trig_stop !== 1'b1) begin failures++; $display("FAIL start_trig got=%0b want=1", trig_stop); end
      pulse_bx0();
      checks++; if (bxn !== 12'd1) begin failures++; $display("FAIL align_bxn got=%0d want=1", bxn); end
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL align_run got=%0d want=3", state); end
      checks++; if (trig_stop !== 1'b1) begin failures++; $display("FAIL align_trig_t1 got=%0b want=1", trig_stop); end
      tick();
      checks++; if (trig_stop !== 1'b0) begin failures++; $display("FAIL align_trig_t2 got=%0b want=0", trig_stop); end
      idle(ORBIT - 2);  // now at the next expected BX0 cycle
   endtask

   task automatic test_steady();
      for (int o = 0; o < 10; o++) begin
         checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL steady_bxn orbit=%0d got=%0d want=0", o, bxn); end
         pulse_bx0();
         idle(ORBIT - 1);
      end
      checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL steady_err got=%0b want=0", sync_err); end
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL steady_cnt got=%0d want=0", err_cnt); end
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL steady_state got=%0d want=3", state); end
   endtask

   task automatic test_shifted();
      checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL shift_bxn0 got=%0d want=0", bxn); end
      tick();  // BX0 missing at bxn 0: miss 1
      checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL shift_cnt1 got=%0d want=1", err_cnt); end
      checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL shift_err got=%0b want=1", sync_err); end
      pulse_bx0();  // late BX0 at bxn 1: miss 2
      checks++; if (err_cnt !== 16'd2) begin failures++; $display("FAIL shift_cnt2 got=%0d want=2", err_cnt); end
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL shift_still_run got=%0d want=3", state); end
      idle(ORBIT - 2);
      checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL shift_bxn_next got=%0d want=0", bxn); end
      tick();  // miss 3
      checks++; if (state !== 3'd4) begin failures++; $display("FAIL shift_error got=%0d want=4", state); end
      checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL shift_cnt3 got=%0d want=3", err_cnt); end
      checks++; if (trig_stop !== 1'b0) begin failures++; $display("FAIL shift_trig_t1 got=%0b want=0", trig_stop); end
      tick();
      checks++; if (trig_stop !== 1'b1) begin failures++; $display("FAIL shift_trig_t2 got=%0b want=1", trig_stop); end
`ifdef FMM_AUTO_RECOVER_EN
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL auto_wait got=%0d want=2", state); end
      checks++; if (sync_err !== 1'b1) begin failures++; $display("FAIL auto_err_kept got=%0b want=1", sync_err); end
`else
      idle(10);
      checks++; if (state !== 3'd4) begin failures++; $display("FAIL error_sticky got=%0d want=4", state); end
`endif
   endtask

   task automatic test_resync();
      ttc_resync = 1'b1;
      tick();
      ttc_resync = 1'b0;
      checks++; if (state !== 3'd1) begin failures++; $display("FAIL resync_state got=%0d want=1", state); end
      checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL resync_bxn got=%0d want=0", bxn); end
      checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL resync_err got=%0b want=0", sync_err); end
      pulse_bx0();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL resync_run got=%0d want=3", state); end
      checks++; if (bxn !== 12'd1) begin failures++; $display("FAIL resync_bxn1 got=%0d want=1", bxn); end
      tick();
      checks++; if (trig_stop !== 1'b0) begin failures++; $display("FAIL resync_trig got=%0b want=0", trig_stop); end
      checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL resync_cnt_kept got=%0d want=3", err_cnt); end
   endtask

   task automatic test_simultaneous();
      idle(50);
      ttc_resync = 1'b1; ttc_bx0 = 1'b1;
      tick();
      ttc_resync = 1'b0; ttc_bx0 = 1'b0;
      checks++; if (state !== 3'd1) begin failures++; $display("FAIL simul_state got=%0d want=1", state); end
      checks++; if (bxn !== 12'd0) begin failures++; $display("FAIL simul_bxn got=%0d want=0", bxn); end
      checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL simul_cnt got=%0d want=3", err_cnt); end
      tick();
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL simul_wait got=%0d want=2", state); end
      checks++; if (bxn !== 12'd1) begin failures++; $display("FAIL simul_bxn1 got=%0d want=1", bxn); end
   endtask

   task automatic test_dont_wait();
      reset = 1'b1;
      tick();
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL dw_reset_cnt got=%0d want=0", err_cnt); end
      dont_wait = 1'b1; reset = 1'b0;
      tick();
      checks++; if (state !== 3'd2) begin failures++; $display("FAIL dw_wait got=%0d want=2", state); end
      tick();
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL dw_run got=%0d want=3", state); end
      tick();
      checks++; if (trig_stop !== 1'b0) begin failures++; $display("FAIL dw_trig got=%0b want=0", trig_stop); end
      idle(97);
      checks++; if (bxn !== 12'd100) begin failures++; $display("FAIL dw_bxn got=%0d want=100", bxn); end
      pulse_bx0();
      idle(ORBIT);  // also crosses bxn 0 with no BX0
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL dw_cnt got=%0d want=0", err_cnt); end
      checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL dw_err got=%0b want=0", sync_err); end
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL dw_state got=%0d want=3", state); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_steady();
      test_shifted();
      test_resync();
      test_simultaneous();
      test_dont_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fmm_bx_sync.md
# fmm_bx_sync

Parametrised successor to the OptoHybrid FMM trigger-stop logic. It combines the startup/resync/wait-for-BX0 state machine with a bunch-crossing counter and continuous BX0 alignment checking. Persistent BX0 misalignment forces trigger stop and enters an error state. It sits in the control block between the TTC decoder and the trigger sequencer, and replaces the fixed single-mode FMM.

## Interface
- BXN_WIDTH, 12: bunch-crossing counter width.
- BXN_MAX, 3563: last BX of the orbit; the counter wraps to 0 after it.
- BXN_OFFSET, 0: BX number assigned to the BX0 cycle; must be ≤ BXN_MAX.
- MAX_BX0_MISS, 3: number of consecutive BX0 misses in RUN that forces ERROR; ≥1.
- ERR_CNT_WIDTH, 16: width of the total-miss counter.
- clock, in, 1: 40 MHz clock.
- reset, in, 1: synchronous, active-high.
- ttc_bx0, in, 1: decoded TTC BX0, one-cycle strobe.
- ttc_resync, in, 1: decoded TTC resync, one-cycle strobe.
- dont_wait, in, 1: level. Skip BX0 alignment and mask BX0 checking.
- fmm_trig_stop, out, 1: high means trigger sequencer stopped.
- bxn, out, BXN_WIDTH: current bunch-crossing number.
- bx0_sync_err, out, 1: sticky BX0 miss flag.
- bx0_err_cnt, out, ERR_CNT_WIDTH: total BX0 misses, saturating.
- fmm_state, out, 3: state encoding. STARTUP=0, RESYNC=1, WAIT_BX0=2, RUN=3, ERROR=4.

## Operation
- **Reset values:** fmm_trig_stop=1, bxn=0, bx0_sync_err=0, bx0_err_cnt=0, fmm_state=STARTUP, consecutive-miss count=0.
- **State priority:** reset > ttc_resync > state transitions. ttc_resync from any state moves to RESYNC; a ttc_bx0 in the same cycle is ignored.
- **State transitions:**
  - STARTUP→WAIT_BX0 on the first cycle with reset low.
  - RESYNC→RUN if ttc_bx0 is high, otherwise RESYNC→WAIT_BX0.
  - WAIT_BX0→RUN on ttc_bx0 or dont_wait.
  - RUN→ERROR when the consecutive-miss count reaches MAX_BX0_MISS.
  - ERROR holds until resync or reset (see Configuration).
  - Illegal encodings go to STARTUP.
- **BX counter:**
  - Free-runs every cycle: next = (bxn==BXN_MAX) ? 0 : bxn+1.
  - On ttc_resync: next = BXN_OFFSET.
  - On ttc_bx0 in WAIT_BX0: next = BXN_OFFSET+1, wrapped to 0 if BXN_OFFSET==BXN_MAX. The BX0 cycle is therefore BX BXN_OFFSET.
- **BX0 check:** active only in RUN with dont_wait=0. A miss is either of:
  - bxn==BXN_OFFSET with ttc_bx0 low;
  - ttc_bx0 high with bxn≠BXN_OFFSET.
  
  A one-cycle-shifted BX0 therefore produces 2 misses per orbit.
- **Miss handling:** each miss sets bx0_sync_err, increments bx0_err_cnt (saturating at all-ones) and increments the consecutive-miss count. A correct BX0 (ttc_bx0 high and bxn==BXN_OFFSET) clears the consecutive-miss count.
- **Realignment:** the counter is not realigned in RUN. Only resync or the WAIT_BX0 path aligns it.
- **Clearing:** resync clears bx0_sync_err and the consecutive-miss count. bx0_err_cnt clears only on reset.
- **dont_wait:** masks misses in RUN and never leads to ERROR.

## Timing
- fmm_state, bxn and the error outputs are registered and update on the clock edge after the cause.
- fmm_trig_stop <= (fmm_state != RUN), i.e. one extra cycle behind fmm_state. It is forced to 1 during reset.
- Resync at cycle T with BX0 at T+1: bxn=BXN_OFFSET at T+1, RUN at T+2, trig_stop=0 at T+3.
- The MAX_BX0_MISS-th miss at cycle T gives ERROR at T+1 and trig_stop=1 at T+2.
- Reset asserted mid-RUN: all outputs take reset values on the next edge.

## Configuration
- FMM_AUTO_RECOVER_EN, defined: ERROR moves to WAIT_BX0 on the next cycle and realigns on the next BX0. bx0_sync_err stays set. trig_stop remains 1 until RUN is re-entered.
- FMM_AUTO_RECOVER_EN, undefined: ERROR is sticky until ttc_resync or reset.

## Structure
- **Package fmm_pkg:** state encodings (FMM_STARTUP…FMM_ERROR), state width constant, default BXN_MAX=3563.
- **Sub-module fmm_bxn_counter:** wrapping counter with load-offset and load-offset+1 controls. It outputs bxn and the comparison bxn==BXN_OFFSET.
- **Top level:** the state machine, the miss logic and the counters.

## Test plan
- **Startup alignment:** reset released, no BX0 for 5000 cycles → state WAIT_BX0, trig_stop=1. BX0 at T → bxn=1 at T+1, RUN at T+1, trig_stop=0 at T+2.
- **Steady operation:** BX0 every 3564 cycles for 10 orbits after alignment → bxn=0 on every BX0 cycle, bx0_sync_err=0, bx0_err_cnt=0.
- **Shifted BX0:** BX0 delayed 1 cycle from the second orbit → misses 1 and 2 in that orbit, miss 3 at the next expected BX. Then ERROR, trig_stop=1, bx0_err_cnt=3, bx0_sync_err=1.
- **Recovery by resync:** from ERROR, resync then BX0 one cycle later → RUN, bx0_sync_err=0, bx0_err_cnt still 3. With FMM_AUTO_RECOVER_EN, ERROR→WAIT_BX0 after 1 cycle.
- **Simultaneous resync and BX0:** both in the same cycle → state RESYNC, BX0 ignored, bxn=BXN_OFFSET the next cycle. With no BX0 following → WAIT_BX0.
- **dont_wait:** dont_wait=1 with no BX0 → RUN 2 cycles after reset release. A stray BX0 at bxn=100 → no error counted.
